rib_xbar: RTL and testbench
===========================

Name: rib_xbar

Overview:
- Next-generation RIB bus interconnect. It connects NM masters (core IFU/LSU, debug, DMA) to NS address-decoded slaves (ROM, RAM, GPIO, timer, …).
- It adds registered one-outstanding-transaction sequencing, round-robin or fixed-priority arbitration, slave back-pressure, decode-error and timeout responses, and per-master stall flags.
- It sits between the core/peripheral masters and the memory-mapped slaves, replacing the 2×3 combinational bus.

Parameters:
- NM, 4, number of masters (2..8)
- NS, 4, number of slaves (1..16); slave index = addr[AW-1:AW-4]
- AW, 32, address width
- DW, 32, data width
- ARB_MODE, 1, 1 = round-robin; 0 = fixed priority, lowest index wins
- TIMEOUT, 255, max cycles waiting s_ready before an error response (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_req  in  NM  per-master access request
- m_we  in  NM  per-master write flag
- m_addr  in  NM*AW  per-master address, master i at [i*AW +: AW]
- m_wdata  in  NM*DW  per-master write data
- m_gnt  out  NM  one-hot grant; request accepted this cycle
- m_rvalid  out  NM  one-cycle response pulse to the owner
- m_err  out  NM  qualifies m_rvalid: decode error or timeout
- m_rdata  out  NM*DW  per-master read data, held until that master's next response
- hold_flag  out  NM  m_req[i] & ~m_gnt[i] & ~m_rvalid[i]; pipeline stall request
- s_sel  out  NS  one-hot slave select, active during ACCESS
- s_we  out  1  write flag to the selected slave
- s_addr  out  AW  {4'h0, addr[AW-5:0]}
- s_wdata  out  DW  write data
- s_rdata  in  NS*DW  per-slave read data
- s_ready  in  NS  slave completes access this cycle

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM→IDLE, rr_ptr=0, timeout counter=0.
  - m_gnt, m_rvalid, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata all 0.
  - Reset mid-ACCESS aborts silently: the owner gets no response.
- FSM states: IDLE, ACCESS, ERR.
- IDLE:
  - If any m_req is set, m_gnt is combinationally the winner's one-hot bit.
  - On the clock edge, latch owner, we, addr, wdata and decoded slave index.
  - If slave index < NS, go to ACCESS; otherwise go to ERR.
  - If no m_req is set, m_gnt=0.
- Master obligation: hold req/we/addr/wdata stable until m_gnt is seen. Deassert req or present a new request the cycle after m_gnt.
- Arbitration:
  - Round-robin: search indices rr_ptr, rr_ptr+1, … mod NM; the first set m_req wins. On grant, rr_ptr←(winner+1) mod NM.
  - Fixed priority: lowest set index wins; rr_ptr is unused.
- ACCESS:
  - s_sel[slave]=1; s_we, s_addr, s_wdata are driven from the latched values.
  - The counter increments each cycle s_ready[slave]=0.
  - When s_ready[slave]=1: m_rdata[owner]←s_rdata[slave] (writes also capture it), m_rvalid[owner]=1 next cycle, m_err=0, go to IDLE, counter cleared.
  - When the counter reaches TIMEOUT with no ready: deassert s_sel, m_rvalid[owner]=1 with m_err[owner]=1, m_rdata[owner]=0, go to IDLE.
- ERR (one cycle): no slave access. Next cycle m_rvalid[owner]=1, m_err[owner]=1, m_rdata[owner]=0; go to IDLE.
- Latency:
  - Request with immediate s_ready: m_gnt in cycle 0, ACCESS in cycle 1, m_rvalid in cycle 2.
  - The FSM is IDLE in cycle 2, so a new grant can coincide with the previous response pulse. That includes the same master.
- Only s_ready of the selected slave is observed; ready from other slaves is ignored.
- m_rvalid and m_err are single-cycle pulses; non-owners stay 0.
- s_we=0 and s_sel=0 whenever the FSM is not in ACCESS.

Test Plan:
- Single read: m0 reads 0x1000_0010, slave1 ready immediately, s_rdata1=0xDEADBEEF → m_gnt[0] in cycle 0; s_sel=4'b0010 and s_addr=0x0000_0010 in cycle 1; m_rvalid[0]=1 and m_rdata0=0xDEADBEEF in cycle 2.
- Round-robin fairness: ARB_MODE=1, all four masters hold req, slaves always ready → grant order 0,1,2,3,0 on consecutive transactions. hold_flag is high for each waiting master.
- Fixed priority: ARB_MODE=0, m0 and m2 request continuously → m0 granted every transaction; m2 hold_flag stays 1.
- Back-pressure and timeout:
  - m1 writes 0x2000_0004 with data 0x5A; s_ready2 low for 3 cycles → s_we=1 and s_sel=4'b0100 for 4 cycles, then m_rvalid[1]=1 with m_err=0.
  - With TIMEOUT=8 and ready never asserted → m_rvalid[1]=1, m_err[1]=1, m_rdata1=0.
- Decode error: NS=3, m3 accesses 0x5000_0000 → s_sel stays 0; m_rvalid[3]=1 and m_err[3]=1 two cycles after the grant.
- Reset mid-access: assert rst during ACCESS → next cycle s_sel=0, m_rvalid=0; no response is issued afterwards. The first grant after reset goes to the lowest requesting index (rr_ptr=0).

Source files
------------

// File: rtl/rib_xbar.sv
// rib_xbar: RIB interconnect joining NM masters to NS address-decoded slaves.
// One transaction is outstanding at a time. Arbitration is round-robin or
// fixed-priority. Slaves may stall with s_ready, and a stall longer than
// TIMEOUT cycles ends in an error response. Addresses whose slave index has
// no slave behind it are answered with a decode error.
module rib_xbar #(
  parameter int NM       = 4,
  parameter int NS       = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_req,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_wdata,
  output logic [NM-1:0]    m_gnt,
  output logic [NM-1:0]    m_rvalid,
  output logic [NM-1:0]    m_err,
  output logic [NM*DW-1:0] m_rdata,
  output logic [NM-1:0]    hold_flag,
  output logic [NS-1:0]    s_sel,
  output logic             s_we,
  output logic [AW-1:0]    s_addr,
  output logic [DW-1:0]    s_wdata,
  input  logic [NS*DW-1:0] s_rdata,
  input  logic [NS-1:0]    s_ready
);

  localparam int MIW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;

  state_t         state_reg;
  logic [MIW-1:0] rr_ptr_reg;
  logic [MIW-1:0] owner_reg;
  logic           we_reg;
  logic [AW-5:0]  addr_reg;
  logic [DW-1:0]  wdata_reg;
  logic [3:0]     slv_reg;
  logic [CW-1:0]  cnt_reg;
  logic [NM-1:0]  rvalid_reg;
  logic [NM-1:0]  err_reg;
  logic [DW-1:0]  rdata_reg [NM];

  logic [MIW-1:0] win_idx;
  logic           win_valid;
  int             arb_cand;
  logic [AW-1:0]  win_addr;
  logic [3:0]     win_slv;
  logic           sel_ready;
  logic [DW-1:0]  sel_rdata;
  logic           in_access;

  // Pick the winning master. Scanning from the far end backwards leaves the
  // candidate nearest the search start as the last one assigned.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    arb_cand  = 0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (ARB_MODE == 1) arb_cand = (int'(rr_ptr_reg) + k) % NM;
      else               arb_cand = k;
      if (m_req[arb_cand]) begin
        win_idx   = MIW'(arb_cand);
        win_valid = 1'b1;
      end
    end
  end

  assign win_addr = m_addr[win_idx*AW +: AW];
  assign win_slv  = win_addr[AW-1:AW-4];

  // Route ready/read data of the latched slave only; other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int j = 0; j < NS; j++) begin
      if (slv_reg == 4'(j)) begin
        sel_ready = s_ready[j];
        sel_rdata = s_rdata[j*DW +: DW];
      end
    end
  end

  assign in_access = (state_reg == ACCESS);
  assign m_gnt     = (state_reg == IDLE && win_valid && !rst) ? (NM'(1) << win_idx) : '0;
  assign m_rvalid  = rvalid_reg;
  assign m_err     = err_reg;
  assign hold_flag = m_req & ~m_gnt & ~m_rvalid;
  assign s_we      = in_access & we_reg;
  assign s_addr    = in_access ? {4'h0, addr_reg} : '0;
  assign s_wdata   = in_access ? wdata_reg : '0;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_sel
      assign s_sel[gi] = in_access && (slv_reg == 4'(gi));
    end
    for (genvar gi = 0; gi < NM; gi++) begin : g_rdata
      assign m_rdata[gi*DW +: DW] = rdata_reg[gi];
    end
  endgenerate

  // Transaction sequencer: grant/latch in IDLE, wait for ready or timeout in
  // ACCESS, and answer decode errors from ERR. Responses are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      slv_reg    <= '0;
      cnt_reg    <= '0;
      rvalid_reg <= '0;
      err_reg    <= '0;
      for (int i = 0; i < NM; i++) rdata_reg[i] <= '0;
    end else begin
      rvalid_reg <= '0;
      err_reg    <= '0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            owner_reg <= win_idx;
            we_reg    <= m_we[win_idx];
            addr_reg  <= win_addr[AW-5:0];
            wdata_reg <= m_wdata[win_idx*DW +: DW];
            slv_reg   <= win_slv;
            cnt_reg   <= '0;
            if (ARB_MODE == 1) rr_ptr_reg <= MIW'((int'(win_idx) + 1) % NM);
            state_reg <= (int'(win_slv) < NS) ? ACCESS : ERR;
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            rdata_reg[owner_reg]  <= sel_rdata;
            rvalid_reg[owner_reg] <= 1'b1;
            cnt_reg               <= '0;
            state_reg             <= IDLE;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th cycle without ready: give up.
            rdata_reg[owner_reg]  <= '0;
            rvalid_reg[owner_reg] <= 1'b1;
            err_reg[owner_reg]    <= 1'b1;
            cnt_reg               <= '0;
            state_reg             <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ERR: begin
          rdata_reg[owner_reg]  <= '0;
          rvalid_reg[owner_reg] <= 1'b1;
          err_reg[owner_reg]    <= 1'b1;
          state_reg             <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_xbar.sv
// tb_rib_xbar: directed scoreboard bench for rib_xbar.
// Instance "dut" is round-robin with three slaves and a short timeout;
// instance "dut_fp" is fixed-priority with four slaves.
module tb_rib_xbar;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] S0 = 32'h1111_0000;
  localparam logic [31:0] S1 = 32'hDEAD_BEEF;
  localparam logic [31:0] S2 = 32'h2222_2222;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NM-1:0]    m_req, m_we, b_req;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;

  logic [NM-1:0]    m_gnt, m_rvalid, m_err, hold_flag;
  logic [NM*DW-1:0] m_rdata;
  logic [2:0]       s_sel;
  logic             s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [3*DW-1:0]  s_rdata;
  logic [2:0]       s_ready;

  logic [NM-1:0]    b_gnt, b_rvalid, b_err, b_hold;
  logic [NM*DW-1:0] b_rdata;
  logic [3:0]       b_sel;
  logic             b_we;
  logic [AW-1:0]    b_addr;
  logic [DW-1:0]    b_wdata;
  logic [4*DW-1:0]  b_s_rdata;
  logic [3:0]       b_s_ready;

  rib_xbar #(.NM(NM), .NS(3), .AW(AW), .DW(DW), .ARB_MODE(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
    .hold_flag(hold_flag), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  rib_xbar #(.NM(NM), .NS(4), .AW(AW), .DW(DW), .ARB_MODE(0), .TIMEOUT(8)) dut_fp (
    .clk(clk), .rst(rst), .m_req(b_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(b_gnt), .m_rvalid(b_rvalid), .m_err(b_err), .m_rdata(b_rdata),
    .hold_flag(b_hold), .s_sel(b_sel), .s_we(b_we), .s_addr(b_addr),
    .s_wdata(b_wdata), .s_rdata(b_s_rdata), .s_ready(b_s_ready)
  );

  typedef struct packed {
    logic [1:0]  m;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t rsp_q[$];
  int   gnt_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   e_g;
  rsp_t e_r;
  bit   got;
  logic [3:0] hold_exp [5] = '{4'b1110, 4'b1100, 4'b1001, 4'b0011, 4'b0110};
  int   rr_order [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk_rsp(input int m, input bit e, input logic [31:0] d);
    rsp_t r;
    r.m    = 2'(m);
    r.err  = e;
    r.data = d;
    return r;
  endfunction

  task automatic set_m(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
    m_we[m]            = we;
    m_addr[m*AW +: AW] = a;
    m_wdata[m*DW +: DW] = d;
    m_req[m]           = 1'b1;
  endtask

  // Returns at the falling edge of the cycle where a masked grant shows.
  task automatic wait_gnt(input logic [3:0] mask, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ((m_gnt & mask) != 4'b0);
    end
    chk({name, "_gnt_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every grant and response of the main instance is matched
  // against the expectation queues in issue order.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_gnt != 4'b0) begin
        if (gnt_q.size() == 0) chk("unexpected_gnt", 32'(m_gnt), 32'd0);
        else begin
          e_g = gnt_q.pop_front();
          chk("gnt_onehot", 32'(m_gnt), 32'd1 << e_g);
        end
      end
      if (m_rvalid != 4'b0) begin
        if (rsp_q.size() == 0) chk("unexpected_rvalid", 32'(m_rvalid), 32'd0);
        else begin
          e_r = rsp_q.pop_front();
          chk("rsp_owner", 32'(m_rvalid), 32'd1 << e_r.m);
          chk("rsp_err", 32'(m_err), e_r.err ? (32'd1 << e_r.m) : 32'd0);
          chk("rsp_rdata", m_rdata[int'(e_r.m)*DW +: DW], e_r.data);
        end
      end else if (m_err != 4'b0) begin
        chk("err_without_rvalid", 32'(m_err), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_req = '0; b_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_rdata = {S2, S1, S0};
    s_ready = 3'b111;
    b_s_rdata = {32'h3333_3333, S2, S1, S0};
    b_s_ready = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", 32'(s_sel), 32'd0);
    chk("rst_we", 32'(s_we), 32'd0);
    chk("rst_addr", s_addr, 32'd0);
    chk("rst_wdata", s_wdata, 32'd0);
    chk("rst_rvalid", 32'(m_rvalid), 32'd0);
    chk("rst_rdata", 32'(|m_rdata), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Round-robin: all four masters hold requests to slave 0.
    for (int k = 0; k < 5; k++) begin
      gnt_q.push_back(rr_order[k]);
      rsp_q.push_back(mk_rsp(rr_order[k], 1'b0, S0));
    end
    for (int m = 0; m < NM; m++) set_m(m, 1'b0, 32'h0000_0100 + 32'(m * 4), 32'h0);
    for (int k = 0; k < 5; k++) begin
      wait_gnt(4'hF, "rr");
      chk("rr_hold", 32'(hold_flag), 32'(hold_exp[k]));
      next_cycle();
    end
    m_req = '0;
    repeat (3) next_cycle();

    // Single read of slave 1 with immediate ready.
    gnt_q.push_back(0);
    rsp_q.push_back(mk_rsp(0, 1'b0, S1));
    set_m(0, 1'b0, 32'h1000_0010, 32'h0);
    @(negedge clk);
    chk("rd_gnt_c0", 32'(m_gnt), 32'h1);
    next_cycle();
    m_req[0] = 1'b0;
    @(negedge clk);
    chk("rd_sel_c1", 32'(s_sel), 32'h2);
    chk("rd_addr_c1", s_addr, 32'h0000_0010);
    chk("rd_we_c1", 32'(s_we), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rd_rvalid_c2", 32'(m_rvalid), 32'h1);
    chk("rd_rdata_c2", m_rdata[0 +: DW], S1);
    next_cycle();

    // Write with back-pressure: slave 2 stalls three cycles.
    s_ready[2] = 1'b0;
    gnt_q.push_back(1);
    rsp_q.push_back(mk_rsp(1, 1'b0, S2));
    set_m(1, 1'b1, 32'h2000_0004, 32'h0000_005A);
    @(negedge clk);
    chk("bp_gnt", 32'(m_gnt), 32'h2);
    next_cycle();
    m_req[1] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) s_ready[2] = 1'b1;
      @(negedge clk);
      chk("bp_sel", 32'(s_sel), 32'h4);
      chk("bp_we", 32'(s_we), 32'h1);
      chk("bp_addr", s_addr, 32'h0000_0004);
      chk("bp_wdata", s_wdata, 32'h0000_005A);
      next_cycle();
    end
    @(negedge clk);
    chk("bp_sel_off", 32'(s_sel), 32'h0);
    chk("bp_rvalid", 32'(m_rvalid), 32'h2);
    chk("bp_err", 32'(m_err), 32'h0);
    next_cycle();

    // Timeout: slave 2 never ready, other slaves ready the whole time.
    s_ready[2] = 1'b0;
    gnt_q.push_back(1);
    rsp_q.push_back(mk_rsp(1, 1'b1, 32'h0));
    set_m(1, 1'b0, 32'h2000_0008, 32'h0);
    wait_gnt(4'h2, "to");
    next_cycle();
    m_req[1] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 15 && !got; i++) begin
      @(negedge clk);
      got = m_rvalid[1];
    end
    chk("to_rvalid_seen", 32'(got), 32'd1);
    chk("to_sel_off", 32'(s_sel), 32'h0);
    next_cycle();
    s_ready[2] = 1'b1;

    // Decode error: slave index 5 does not exist.
    gnt_q.push_back(3);
    rsp_q.push_back(mk_rsp(3, 1'b1, 32'h0));
    set_m(3, 1'b0, 32'h5000_0000, 32'h0);
    @(negedge clk);
    chk("de_gnt", 32'(m_gnt), 32'h8);
    next_cycle();
    m_req[3] = 1'b0;
    @(negedge clk);
    chk("de_sel", 32'(s_sel), 32'h0);
    chk("de_we", 32'(s_we), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("de_rvalid", 32'(m_rvalid), 32'h8);
    chk("de_err", 32'(m_err), 32'h8);
    next_cycle();

    // Reset in the middle of a stalled access: no response may follow.
    s_ready[2] = 1'b0;
    gnt_q.push_back(2);
    set_m(2, 1'b0, 32'h2000_0000, 32'h0);
    @(negedge clk);
    chk("ra_gnt", 32'(m_gnt), 32'h4);
    next_cycle();
    m_req[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("ra_sel_before", 32'(s_sel), 32'h4);
    next_cycle();
    rst = 1'b0;
    s_ready[2] = 1'b1;
    gnt_q.push_back(1);
    gnt_q.push_back(3);
    rsp_q.push_back(mk_rsp(1, 1'b0, S1));
    rsp_q.push_back(mk_rsp(3, 1'b0, S0));
    set_m(1, 1'b0, 32'h1000_0000, 32'h0);
    set_m(3, 1'b0, 32'h0000_0000, 32'h0);
    @(negedge clk);
    chk("ra_sel_after", 32'(s_sel), 32'h0);
    chk("ra_rvalid_after", 32'(m_rvalid), 32'h0);
    chk("ra_rdata_cleared", 32'(|m_rdata), 32'h0);
    chk("ra_first_gnt", 32'(m_gnt), 32'h2);
    next_cycle();
    m_req[1] = 1'b0;
    wait_gnt(4'h8, "ra_m3");
    next_cycle();
    m_req[3] = 1'b0;
    repeat (6) next_cycle();

    // Fixed priority: m0 and m2 request continuously on the second instance.
    m_addr[0*AW +: AW] = 32'h0000_0040;
    m_addr[2*AW +: AW] = 32'h0000_0080;
    m_we  = '0;
    b_req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        got = (b_gnt != 4'b0);
      end
      chk("fp_gnt", 32'(b_gnt), 32'h1);
      chk("fp_hold2_gnt", 32'(b_hold[2]), 32'h1);
      next_cycle();
      @(negedge clk);
      chk("fp_hold2_acc", 32'(b_hold[2]), 32'h1);
    end
    next_cycle();
    b_req[0] = 1'b0;
    @(negedge clk);
    chk("fp_m2_after_m0", 32'(b_gnt), 32'h4);
    next_cycle();
    b_req = '0;
    repeat (4) next_cycle();

    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
